// File: rtl/wb_merge_buffer_if.sv
// Shared types and the result/write-back bundle
// for the write-back merge buffer.
package wb_merge_pkg;
  localparam int XLEN = 32;
  localparam int TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               ex;
  } wb_entry_t;
endpackage

interface wb_merge_if
  import wb_merge_pkg::*;
#(
  parameter int NR_SRC = 4,
  parameter int NR_WB  = 2
) ();
  logic [NR_SRC-1:0]                    src_valid_i;
  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0] src_trans_id_i;
  logic [NR_SRC-1:0][XLEN-1:0]          src_result_i;
  exception_t [NR_SRC-1:0]              src_ex_i;
  logic [NR_SRC-1:0]                    almost_full_o;
  logic [NR_WB-1:0]                     wb_valid_o;
  logic [NR_WB-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o;
  logic [NR_WB-1:0][XLEN-1:0]           wb_result_o;
  exception_t [NR_WB-1:0]               wb_ex_o;
  logic                                 overflow_o;

  modport slave (
    input  src_valid_i,
    input  src_trans_id_i,
    input  src_result_i,
    input  src_ex_i,
    output almost_full_o,
    output wb_valid_o,
    output wb_trans_id_o,
    output wb_result_o,
    output wb_ex_o,
    output overflow_o
  );

  modport master (
    output src_valid_i,
    output src_trans_id_i,
    output src_result_i,
    output src_ex_i,
    input  almost_full_o,
    input  wb_valid_o,
    input  wb_trans_id_o,
    input  wb_result_o,
    input  wb_ex_o,
    input  overflow_o
  );
endinterface

// File: rtl/wb_merge_buffer.sv
// Per-source result FIFOs retired over NR_WB
// scoreboard ports with round-robin arbitration.
module wb_merge_buffer
  import wb_merge_pkg::*;
#(
  parameter int NR_SRC   = 4,
  parameter int NR_WB    = 2,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 2
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       flush_i,
  wb_merge_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  wb_entry_t         mem_q [NR_SRC][DEPTH];
  logic [PW-1:0]     rd_ptr_q [NR_SRC];
  logic [PW-1:0]     wr_ptr_q [NR_SRC];
  logic [CW-1:0]     count_q [NR_SRC];
  logic [RW-1:0]     rr_q;
  logic [RW-1:0]     rr_d;
  logic              ovf_q;

  wb_entry_t         head [NR_SRC];
  wb_entry_t         in_e [NR_SRC];
  wb_entry_t         out_e [NR_WB];
  logic [NR_SRC-1:0] empty;
  logic [NR_SRC-1:0] full;
  logic [NR_SRC-1:0] pop;
  logic [NR_SRC-1:0] push;
  logic [NR_SRC-1:0] drop;
  logic [NR_SRC-1:0] af;
  logic [NR_WB-1:0]  gnt_vld;
  logic [RW-1:0]     gnt_src [NR_WB];

  logic [NR_WB-1:0][TRANS_ID_BITS-1:0] wb_id;
  logic [NR_WB-1:0][XLEN-1:0]          wb_res;
  exception_t [NR_WB-1:0]              wb_ex;

  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      empty[s] = (count_q[s] == '0);
      full[s]  = (count_q[s] == CW'(DEPTH));
      af[s]    = (count_q[s] >= CW'(AF_LEVEL));
      head[s]  = mem_q[s][rd_ptr_q[s]];
      in_e[s].trans_id = bus.src_trans_id_i[s];
      in_e[s].result   = bus.src_result_i[s];
      in_e[s].ex       = bus.src_ex_i[s];
    end
  end

  // Cyclic scan from rr_q; each source granted at most once.
  always_comb begin
    int n;
    int idx;
    n       = 0;
    idx     = 0;
    pop     = '0;
    gnt_vld = '0;
    rr_d    = rr_q;
    for (int p = 0; p < NR_WB; p++) begin
      gnt_src[p] = '0;
    end
    for (int k = 0; k < NR_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NR_SRC) idx = idx - NR_SRC;
      if (!flush_i && !empty[idx] && n < NR_WB) begin
        pop[idx]   = 1'b1;
        gnt_vld[n] = 1'b1;
        gnt_src[n] = RW'(idx);
        rr_d       = RW'((idx + 1) % NR_SRC);
        n          = n + 1;
      end
    end
  end

  // A full FIFO still accepts when it pops the same cycle.
  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      push[s] = bus.src_valid_i[s] && !flush_i &&
                (!full[s] || pop[s]);
      drop[s] = bus.src_valid_i[s] && !flush_i &&
                full[s] && !pop[s];
    end
  end

  always_comb begin
    for (int p = 0; p < NR_WB; p++) begin
      out_e[p]  = gnt_vld[p] ? head[gnt_src[p]] : '0;
      wb_id[p]  = out_e[p].trans_id;
      wb_res[p] = out_e[p].result;
      wb_ex[p]  = out_e[p].ex;
    end
  end

  assign bus.wb_valid_o    = gnt_vld;
  assign bus.wb_trans_id_o = wb_id;
  assign bus.wb_result_o   = wb_res;
  assign bus.wb_ex_o       = wb_ex;
  assign bus.almost_full_o = af;
  assign bus.overflow_o    = ovf_q;

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NR_SRC; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_e[s];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int s = 0; s < NR_SRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      rr_q  <= '0;
      ovf_q <= 1'b0;
    end else if (flush_i) begin
      for (int s = 0; s < NR_SRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int s = 0; s < NR_SRC; s++) begin
        if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
        if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
        count_q[s] <= count_q[s] + CW'(push[s])
                      - CW'(pop[s]);
      end
      rr_q <= rr_d;
      if (|drop) ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_merge_buffer.sv
// Directed bench for wb_merge_buffer with
// hand-computed expectations.
module tb_wb_merge_buffer;
  import wb_merge_pkg::*;

  logic clk_i;
  logic clr;
  logic flush;
  int   n_chk;
  int   n_err;
  logic [31:0] q [4][$];

  wb_merge_if #(.NR_SRC(4), .NR_WB(2)) bus ();

  wb_merge_buffer #(
    .NR_SRC(4), .NR_WB(2), .DEPTH(4), .AF_LEVEL(2)
  ) dut (
    .clk_i  (clk_i),
    .clr_i  (clr),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.src_valid_i    = '0;
    bus.src_trans_id_i = '0;
    bus.src_result_i   = '0;
    bus.src_ex_i       = '0;
    flush = 1'b0;
  endtask

  task automatic push(int s, int id, logic [31:0] res);
    bus.src_valid_i[s]    = 1'b1;
    bus.src_trans_id_i[s] = 3'(id);
    bus.src_result_i[s]   = res;
    bus.src_ex_i[s].cause = 32'(s);
    bus.src_ex_i[s].tval  = res;
    bus.src_ex_i[s].valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  task automatic port_chk(string tag, int p, int id,
                          logic [31:0] res);
    check($sformatf("%s.v%0d", tag, p),
          64'(bus.wb_valid_o[p]), 64'd1);
    check($sformatf("%s.id%0d", tag, p),
          64'(bus.wb_trans_id_o[p]), 64'(id));
    check($sformatf("%s.res%0d", tag, p),
          64'(bus.wb_result_o[p]), 64'(res));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;

    // reset state
    @(negedge clk_i);
    check("rst.valid", 64'(bus.wb_valid_o), 64'd0);
    check("rst.res0", 64'(bus.wb_result_o[0]), 64'd0);
    check("rst.res1", 64'(bus.wb_result_o[1]), 64'd0);
    check("rst.id", 64'(bus.wb_trans_id_o), 64'd0);
    check("rst.ex", 64'(bus.wb_ex_o[0].valid), 64'd0);
    check("rst.af", 64'(bus.almost_full_o), 64'd0);
    check("rst.ovf", 64'(bus.overflow_o), 64'd0);
    tick();

    // single load result, one cycle latency
    push(1, 3, 32'hDEAD);
    @(negedge clk_i);
    check("ld.nobypass", 64'(bus.wb_valid_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("ld.valid", 64'(bus.wb_valid_o), 64'd1);
    port_chk("ld", 0, 3, 32'hDEAD);
    check("ld.tval", 64'(bus.wb_ex_o[0].tval),
          64'hDEAD);
    check("ld.exv", 64'(bus.wb_ex_o[0].valid), 64'd1);
    check("ld.res1", 64'(bus.wb_result_o[1]), 64'd0);
    tick();
    @(negedge clk_i);
    check("ld.after", 64'(bus.wb_valid_o), 64'd0);
    tick();

    // flush returns rr to 0, then four sources at once
    flush = 1'b1;
    @(negedge clk_i);
    check("fl0.valid", 64'(bus.wb_valid_o), 64'd0);
    tick();
    for (int s = 0; s < 4; s++) push(s, s, 32'h100 + s);
    tick();
    @(negedge clk_i);
    port_chk("all4.a", 0, 0, 32'h100);
    port_chk("all4.a", 1, 1, 32'h101);
    check("all4.af", 64'(bus.almost_full_o), 64'd0);
    tick();
    @(negedge clk_i);
    port_chk("all4.b", 0, 2, 32'h102);
    port_chk("all4.b", 1, 3, 32'h103);
    check("all4.afb", 64'(bus.almost_full_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("all4.c", 64'(bus.wb_valid_o), 64'd0);
    tick();

    // flu and store streaming, in-order retirement
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        push(0, k, 32'h200 + k);
        push(2, k, 32'h280 + k);
      end
      @(negedge clk_i);
      if (k == 0) begin
        check("str.v0", 64'(bus.wb_valid_o), 64'd0);
      end else begin
        port_chk($sformatf("str%0d", k), 0, k - 1,
                 32'h200 + k - 1);
        port_chk($sformatf("str%0d", k), 1, k - 1,
                 32'h280 + k - 1);
      end
      check($sformatf("str%0d.af", k),
            64'(bus.almost_full_o), 64'd0);
      tick();
    end
    check("str.ovf", 64'(bus.overflow_o), 64'd0);

    // flush drops buffered and same-cycle pushes
    push(0, 5, 32'h300);
    push(1, 6, 32'h301);
    push(2, 7, 32'h302);
    @(negedge clk_i);
    check("fl.nobyp", 64'(bus.wb_valid_o), 64'd0);
    tick();
    flush = 1'b1;
    push(1, 4, 32'h3FF);
    @(negedge clk_i);
    check("fl.valid", 64'(bus.wb_valid_o), 64'd0);
    tick();
    push(0, 1, 32'h340);
    push(3, 2, 32'h343);
    @(negedge clk_i);
    check("fl.empty", 64'(bus.wb_valid_o), 64'd0);
    check("fl.af", 64'(bus.almost_full_o), 64'd0);
    tick();
    @(negedge clk_i);
    port_chk("fl.rr", 0, 1, 32'h340);
    port_chk("fl.rr", 1, 2, 32'h343);
    tick();
    @(negedge clk_i);
    check("fl.lost", 64'(bus.wb_valid_o), 64'd0);
    check("fl.ovf", 64'(bus.overflow_o), 64'd0);
    tick();

    // all four push every cycle: fill, full+pop, drop
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 4; s++)
        push(s, k, 32'(s * 16 + k));
      @(negedge clk_i);
      case (k)
        0: check("ov0.v", 64'(bus.wb_valid_o), 64'd0);
        1: begin
          port_chk("ov1", 0, 0, 32'h00);
          port_chk("ov1", 1, 0, 32'h10);
        end
        2: begin
          port_chk("ov2", 0, 0, 32'h20);
          port_chk("ov2", 1, 0, 32'h30);
          check("ov2.af", 64'(bus.almost_full_o),
                64'b1100);
        end
        3: begin
          port_chk("ov3", 0, 1, 32'h01);
          port_chk("ov3", 1, 1, 32'h11);
          check("ov3.af", 64'(bus.almost_full_o),
                64'b1111);
        end
        7: check("ov7.ovf", 64'(bus.overflow_o), 64'd0);
        default: ;
      endcase
      tick();
    end

    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (c == 0)
        check("ov8.ovf", 64'(bus.overflow_o), 64'd1);
      for (int p = 0; p < 2; p++) begin
        if (bus.wb_valid_o[p]) begin
          q[int'(bus.wb_result_o[p][5:4])].push_back(
            bus.wb_result_o[p]);
        end
      end
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      int base;
      base = (s < 2) ? 4 : 3;
      check($sformatf("drain%0d.n", s),
            64'(q[s].size()), 64'd4);
      for (int i = 0; i < q[s].size(); i++) begin
        check($sformatf("drain%0d.%0d", s, i),
              64'(q[s][i]), 64'(s * 16 + base + i));
      end
    end
    @(negedge clk_i);
    check("drain.v", 64'(bus.wb_valid_o), 64'd0);
    check("drain.ovf", 64'(bus.overflow_o), 64'd1);
    tick();

    // sticky overflow survives flush, cleared by clr
    flush = 1'b1;
    tick();
    @(negedge clk_i);
    check("flov.ovf", 64'(bus.overflow_o), 64'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk_i);
    check("clr.ovf", 64'(bus.overflow_o), 64'd0);
    check("clr.af", 64'(bus.almost_full_o), 64'd0);
    check("clr.v", 64'(bus.wb_valid_o), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
